// File: rtl/dbg_uart_pkg.sv
// Shared debug-UART definitions: receiver/transmitter state encoding,
// default clock-divider floor, common widths and a divider clamp helper.
package dbg_uart_pkg;

   localparam int unsigned CNT_W           = 32;
   localparam int unsigned DATA_W          = 8;
   localparam int unsigned DEF_MIN_CLK_DIV = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } uart_state_e;

   // Floor a requested clocks-per-bit value at the honoured minimum.
   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] req,
                                                  input logic [CNT_W-1:0] floor_val);
      return (req < floor_val) ? floor_val : req;
   endfunction

endpackage

// File: rtl/dbg_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports: clk, rst_i (async active-high), d (async input), q (synchronised output).
module dbg_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_i,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) ff <= {STAGES{RST_VAL}};
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/dbg_uart_rx.sv
// Debug UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Ports: clk, rst_i (async active-high), clk_div_i (clocks per bit), rx_enable_i,
//        parity_en_i, rx_i (async line, idle high), rx_data_o (last byte),
//        rx_valid_o (1-cycle completion pulse), rx_err_o (parity/framing error).
module dbg_uart_rx
   import dbg_uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_CLK_DIV = DEF_MIN_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic [CNT_W-1:0]  clk_div_i,
   input  logic              rx_enable_i,
   input  logic              parity_en_i,
   input  logic              rx_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              rx_err_o
);

   uart_state_e       state, state_nxt;
   logic              rx_s, rx_d;
   logic [CNT_W-1:0]  cnt, div;
   logic [DATA_W-1:0] shift;
   logic [2:0]        bit_idx;
   logic              par, perr;
   logic              smp;
   logic [CNT_W-1:0]  div_m1, half_m1;

   dbg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_i (rst_i),
      .d     (rx_i),
      .q     (rx_s)
   );

   assign div_m1  = div - CNT_W'(1);
   assign half_m1 = (div >> 1) - CNT_W'(1);

   // State register
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state and bit-sample strobe
   always_comb begin
      state_nxt = state;
      smp       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_enable_i && !rx_s && rx_d) state_nxt = ST_START;
         end
         ST_START: begin
            if (cnt == half_m1) begin
               smp       = 1'b1;
               state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == div_m1) begin
               smp = 1'b1;
               if (bit_idx == 3'(DATA_W - 1)) state_nxt = par ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (cnt == div_m1) begin
               smp       = 1'b1;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == div_m1) begin
               smp       = 1'b1;
               state_nxt = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Disable aborts any frame in flight; an already-issued pulse still completes
      if (state != ST_IDLE && !rx_enable_i) begin
         state_nxt = ST_IDLE;
         smp       = 1'b0;
      end
   end

   // Datapath: edge detect, bit timer, frame config, shift register, outputs
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         rx_d       <= 1'b1;
         cnt        <= '0;
         div        <= CNT_W'(MIN_CLK_DIV);
         par        <= 1'b0;
         perr       <= 1'b0;
         shift      <= '0;
         bit_idx    <= '0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         rx_err_o   <= 1'b0;
      end else begin
         rx_d       <= rx_s;
         rx_valid_o <= 1'b0;
         rx_err_o   <= 1'b0;

         if (state == ST_IDLE || state_nxt != state || smp) cnt <= '0;
         else                                               cnt <= cnt + CNT_W'(1);

         // Frame configuration is frozen at the start edge
         if (state == ST_IDLE && state_nxt == ST_START) begin
            div     <= clamp_div(clk_div_i, CNT_W'(MIN_CLK_DIV));
            par     <= parity_en_i;
            perr    <= 1'b0;
            bit_idx <= '0;
         end

         if (smp) begin
            case (state)
               ST_DATA: begin
                  shift   <= {rx_s, shift[DATA_W-1:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
               ST_PARITY: perr <= (^shift) ^ rx_s;
               ST_STOP: begin
                  rx_data_o  <= shift;
                  rx_valid_o <= 1'b1;
                  rx_err_o   <= perr | ~rx_s;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Directed self-checking bench for dbg_uart_rx.
module tb_dbg_uart_rx;
   import dbg_uart_pkg::*;

   logic        clk;
   logic        rst_i;
   logic [31:0] clk_div_i;
   logic        rx_enable_i;
   logic        parity_en_i;
   logic        rx_i;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        rx_err_o;

   int errors = 0;
   int checks = 0;

   int         pulse_cnt  = 0;
   logic [7:0] cap_data[$];
   logic       cap_err[$];
   int         long_pulse = 0;
   int         stray_err  = 0;
   logic       prev_valid = 1'b0;

   dbg_uart_rx dut (
      .clk         (clk),
      .rst_i       (rst_i),
      .clk_div_i   (clk_div_i),
      .rx_enable_i (rx_enable_i),
      .parity_en_i (parity_en_i),
      .rx_i        (rx_i),
      .rx_data_o   (rx_data_o),
      .rx_valid_o  (rx_valid_o),
      .rx_err_o    (rx_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rx_valid_o) begin
         pulse_cnt++;
         cap_data.push_back(rx_data_o);
         cap_err.push_back(rx_err_o);
      end
      if (rx_valid_o && prev_valid) long_pulse++;
      if (rx_err_o && !rx_valid_o)  stray_err++;
      prev_valid = rx_valid_o;
   end

   // Drive one line level for bt clock periods (tasks start and end at posedge+1)
   task automatic drive_bit(input logic v, input int bt);
      rx_i = v;
      repeat (bt) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit with_par,
                             input logic par_bit, input logic stop_bit, input int bt);
      drive_bit(1'b0, bt);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bt);
      if (with_par) drive_bit(par_bit, bt);
      drive_bit(stop_bit, bt);
      rx_i = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data_o); end
      checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid_o); end
      checks++; if (rx_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rx_err_o); end
      rst_i = 1'b0;
      idle(5);
   endtask

   task automatic test_basic;
      int n0;
      n0 = pulse_cnt;
      clk_div_i = 50; parity_en_i = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 50);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", pulse_cnt, n0 + 1); end
      checks++; if (cap_data[$] !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", cap_data[$]); end
      checks++; if (cap_err[$] !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", cap_err[$]); end
   endtask

   task automatic test_parity;
      int n0;
      n0 = pulse_cnt;
      parity_en_i = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 50);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL par_bad_count got=%0d exp=%0d", pulse_cnt, n0 + 1); end
      checks++; if (cap_data[$] !== 8'h3C) begin errors++; $display("FAIL par_bad_data got=%h exp=3c", cap_data[$]); end
      checks++; if (cap_err[$] !== 1'b1) begin errors++; $display("FAIL par_bad_err got=%b exp=1", cap_err[$]); end
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 50);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 2) begin errors++; $display("FAIL par_ok_count got=%0d exp=%0d", pulse_cnt, n0 + 2); end
      checks++; if (cap_data[$] !== 8'h3C) begin errors++; $display("FAIL par_ok_data got=%h exp=3c", cap_data[$]); end
      checks++; if (cap_err[$] !== 1'b0) begin errors++; $display("FAIL par_ok_err got=%b exp=0", cap_err[$]); end
      parity_en_i = 1'b0;
   endtask

   task automatic test_break;
      int n0;
      n0 = pulse_cnt;
      drive_bit(1'b0, 20 * 50);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL break_count got=%0d exp=%0d", pulse_cnt, n0 + 1); end
      checks++; if (cap_data[$] !== 8'h00) begin errors++; $display("FAIL break_data got=%h exp=00", cap_data[$]); end
      checks++; if (cap_err[$] !== 1'b1) begin errors++; $display("FAIL break_err got=%b exp=1", cap_err[$]); end
      rx_i = 1'b1;
      idle(100);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL break_idle_count got=%0d exp=%0d", pulse_cnt, n0 + 1); end
      send_frame(8'h33, 1'b0, 1'b0, 1'b1, 50);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 2) begin errors++; $display("FAIL break_recover_count got=%0d exp=%0d", pulse_cnt, n0 + 2); end
      checks++; if (cap_data[$] !== 8'h33) begin errors++; $display("FAIL break_recover_data got=%h exp=33", cap_data[$]); end
   endtask

   task automatic test_glitch;
      int n0;
      n0 = pulse_cnt;
      drive_bit(1'b0, 10);
      rx_i = 1'b1;
      idle(100);
      checks++; if (pulse_cnt !== n0) begin errors++; $display("FAIL glitch_count got=%0d exp=%0d", pulse_cnt, n0); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state, ST_IDLE); end
      checks++; if (rx_data_o !== 8'h33) begin errors++; $display("FAIL glitch_hold got=%h exp=33", rx_data_o); end
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 50);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=%0d", pulse_cnt, n0 + 1); end
      checks++; if (cap_data[$] !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got=%h exp=5a", cap_data[$]); end
      checks++; if (cap_err[$] !== 1'b0) begin errors++; $display("FAIL glitch_next_err got=%b exp=0", cap_err[$]); end
   endtask

   task automatic test_back_to_back;
      int n0;
      n0 = pulse_cnt;
      clk_div_i = 2;
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 4);
      send_frame(8'h80, 1'b0, 1'b0, 1'b1, 4);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 2) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", pulse_cnt, n0 + 2); end
      if (pulse_cnt >= n0 + 2) begin
         checks++; if (cap_data[n0] !== 8'h01) begin errors++; $display("FAIL b2b_data0 got=%h exp=01", cap_data[n0]); end
         checks++; if (cap_data[n0 + 1] !== 8'h80) begin errors++; $display("FAIL b2b_data1 got=%h exp=80", cap_data[n0 + 1]); end
         checks++; if (cap_err[n0 + 1] !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b exp=0", cap_err[n0 + 1]); end
      end
      clk_div_i = 50;
   endtask

   task automatic test_reset_mid_frame;
      int n0;
      n0 = pulse_cnt;
      drive_bit(1'b0, 50);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 50);
      idle(25);
      rst_i = 1'b1;
      #2;
      checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", rx_data_o); end
      checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid_o); end
      checks++; if (rx_err_o !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", rx_err_o); end
      idle(3);
      rst_i = 1'b0;
      idle(300);
      checks++; if (pulse_cnt !== n0) begin errors++; $display("FAIL rstmid_count got=%0d exp=%0d", pulse_cnt, n0); end
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, 50);
      idle(20);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=%0d", pulse_cnt, n0 + 1); end
      checks++; if (cap_data[$] !== 8'h11) begin errors++; $display("FAIL rstmid_next_data got=%h exp=11", cap_data[$]); end
   endtask

   task automatic test_enable_abort;
      int n0;
      n0 = pulse_cnt;
      drive_bit(1'b0, 50);
      drive_bit(1'b1, 50);
      drive_bit(1'b1, 25);
      rx_enable_i = 1'b0;
      drive_bit(1'b1, 25 + 7 * 50);
      rx_enable_i = 1'b1;
      idle(100);
      checks++; if (pulse_cnt !== n0) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", pulse_cnt, n0); end
      checks++; if (rx_data_o !== 8'h11) begin errors++; $display("FAIL abort_hold got=%h exp=11", rx_data_o); end
   endtask

   task automatic test_pulse_shape;
      checks++; if (long_pulse !== 0) begin errors++; $display("FAIL valid_width got=%0d exp=0", long_pulse); end
      checks++; if (stray_err !== 0) begin errors++; $display("FAIL err_outside_valid got=%0d exp=0", stray_err); end
   endtask

   initial begin
      rst_i       = 1'b1;
      rx_i        = 1'b1;
      rx_enable_i = 1'b1;
      parity_en_i = 1'b0;
      clk_div_i   = 32'd50;
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_enable_abort();
      test_pulse_shape();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
